// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUControl codes, ALUOp and funct3 constants shared by the decode stage
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_NOP = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct3/funct7 to ALUControl decoder
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    always_comb begin
        o_alu_control = ALU_NOP;
        o_illegal     = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type with bit 30 set is a subtract; addi never is.
                    F3_ADDSUB: o_alu_control = ({i_op5, i_funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    F3_SLT:    o_alu_control = ALU_SLT;
                    F3_XOR:    o_alu_control = ALU_XOR;
                    F3_AND:    o_alu_control = ALU_AND;
                    default:   o_illegal     = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - decode stage with 2-entry skid buffer feeding the ALU
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_alu_op,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic             in_op5,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_alu_control,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [2:0]       w_dec_ctrl;
    logic             w_dec_ill;
    logic             w_in_xfer;
    logic             w_m_free;

    logic             r_m_valid;
    logic [2:0]       r_m_ctrl;
    logic             r_m_ill;
    logic [WIDTH-1:0] r_m_a;
    logic [WIDTH-1:0] r_m_b;

    logic             r_s_valid;
    logic [2:0]       r_s_ctrl;
    logic             r_s_ill;
    logic [WIDTH-1:0] r_s_a;
    logic [WIDTH-1:0] r_s_b;

    logic [CNT_W-1:0] r_cnt;

    alu_ctrl_decode u_dec (
        .i_alu_op      (in_alu_op),
        .i_funct3      (in_funct3),
        .i_funct7b5    (in_funct7b5),
        .i_op5         (in_op5),
        .o_alu_control (w_dec_ctrl),
        .o_illegal     (w_dec_ill)
    );

    // Ready depends only on the skid flag, so out_ready never reaches in_ready.
    assign in_ready  = !r_s_valid;
    assign w_in_xfer = in_valid && !r_s_valid;
    assign w_m_free  = !r_m_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_m_ill   <= 1'b0;
            r_m_a     <= '0;
            r_m_b     <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
            r_s_ill   <= 1'b0;
            r_s_a     <= '0;
            r_s_b     <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_m_free) begin
            // S full implies in_ready low, so no input competes with the S->M move.
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_ctrl  <= r_s_ctrl;
                r_m_ill   <= r_s_ill;
                r_m_a     <= r_s_a;
                r_m_b     <= r_s_b;
                r_s_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_m_valid <= 1'b1;
                r_m_ctrl  <= w_dec_ctrl;
                r_m_ill   <= w_dec_ill;
                r_m_a     <= in_a;
                r_m_b     <= in_b;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_s_valid <= 1'b1;
            r_s_ctrl  <= w_dec_ctrl;
            r_s_ill   <= w_dec_ill;
            r_s_a     <= in_a;
            r_s_b     <= in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_in_xfer && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid       = r_m_valid;
    assign out_alu_control = r_m_ctrl;
    assign out_illegal     = r_m_ill;
    assign out_a           = r_m_a;
    assign out_b           = r_m_b;
    assign illegal_count   = r_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - self-checking bench for alu_decode_stage
module tb_alu_decode_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   in_alu_op = '0;
    logic [2:0]   in_funct3 = '0;
    logic         in_funct7b5 = 1'b0;
    logic         in_op5 = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;

    logic         in_ready, out_valid, out_illegal;
    logic [2:0]   out_alu_control;
    logic [W-1:0] out_a, out_b;
    logic [7:0]   illegal_count;

    logic         in_ready2, out_valid2, out_illegal2;
    logic [2:0]   out_alu_control2;
    logic [W-1:0] out_a2, out_b2;
    logic [1:0]   illegal_count2;

    alu_decode_stage #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3),
        .in_funct7b5(in_funct7b5), .in_op5(in_op5),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_control(out_alu_control), .out_a(out_a), .out_b(out_b),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    alu_decode_stage #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3),
        .in_funct7b5(in_funct7b5), .in_op5(in_op5),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_alu_control(out_alu_control2), .out_a(out_a2), .out_b(out_b2),
        .out_illegal(out_illegal2), .illegal_count(illegal_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   ctrl;
        logic         ill;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } ent_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       op5;
        logic       f7;
        logic [2:0] ectrl;
        logic       eill;
    } vec_t;

    ent_t q[$];
    int   mcnt = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic op5, input logic f7);
        if (op == 2'd0) return 4'b0_000;
        if (op == 2'd1) return 4'b0_001;
        if (op == 2'd3) return 4'b1_111;
        if (f3 == 3'd0) return (op5 && f7) ? 4'b0_001 : 4'b0_000;
        if (f3 == 3'd2) return 4'b0_101;
        if (f3 == 3'd4) return 4'b0_011;
        if (f3 == 3'd7) return 4'b0_010;
        return 4'b1_111;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic op5, input logic f7, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v; in_alu_op = op; in_funct3 = f3;
        in_op5 = op5; in_funct7b5 = f7; in_a = a; in_b = b;
    endtask

    // Scoreboard step: compare against the FIFO model, then advance one clock.
    task automatic tick();
        int n;
        logic [3:0] d;
        ent_t e;
        n = q.size();
        chk("out_valid", out_valid, n > 0);
        chk("in_ready", in_ready, n < 2);
        chk("illegal_count", illegal_count, mcnt);
        if (n > 0 && out_ready) begin
            chk("sb_a", out_a, q[0].a);
            chk("sb_b", out_b, q[0].b);
            chk("sb_ctrl", out_alu_control, q[0].ctrl);
            chk("sb_ill", out_illegal, q[0].ill);
            void'(q.pop_front());
        end
        if (in_valid && n < 2) begin
            d = ref_decode(in_alu_op, in_funct3, in_op5, in_funct7b5);
            if (d[3] && mcnt < 255) mcnt++;
            e.ctrl = d[2:0]; e.ill = d[3]; e.a = in_a; e.b = in_b;
            if (!flush) q.push_back(e);
        end
        if (flush) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0);
        flush = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mcnt = 0;
    endtask

    vec_t vt[12];
    int   exp_cnt[5];
    logic [W-1:0] got[$];

    initial begin
        vt[0]  = '{2'd0, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0};
        vt[1]  = '{2'd1, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
        vt[2]  = '{2'd2, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
        vt[3]  = '{2'd2, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0};
        vt[4]  = '{2'd2, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
        vt[5]  = '{2'd2, 3'b010, 1'b1, 1'b0, 3'b101, 1'b0};
        vt[6]  = '{2'd2, 3'b100, 1'b0, 1'b0, 3'b011, 1'b0};
        vt[7]  = '{2'd2, 3'b111, 1'b1, 1'b1, 3'b010, 1'b0};
        vt[8]  = '{2'd2, 3'b110, 1'b1, 1'b0, 3'b111, 1'b1};
        vt[9]  = '{2'd2, 3'b001, 1'b1, 1'b0, 3'b111, 1'b1};
        vt[10] = '{2'd3, 3'b000, 1'b0, 1'b0, 3'b111, 1'b1};
        vt[11] = '{2'd2, 3'b011, 1'b0, 1'b0, 3'b111, 1'b1};
        exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3;

        #1;
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ctrl", out_alu_control, 3'd0);
        chk("rst_a", out_a, '0);
        chk("rst_b", out_b, '0);
        chk("rst_ill", out_illegal, 1'b0);
        chk("rst_cnt", illegal_count, 8'd0);

        // Decode table, one op at a time, result one cycle after acceptance
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vt[i].op, vt[i].f3, vt[i].op5, vt[i].f7, W'(i + 100), W'(i * 3));
            tick();
            drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0);
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_ctrl", out_alu_control, vt[i].ectrl);
            chk("vec_ill", out_illegal, vt[i].eill);
            chk("vec_a", out_a, W'(i + 100));
            tick();
        end

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;

        // Reset asserted with M and S full must clear immediately
        out_ready = 1'b0;
        drive(1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 32'd5, 32'd6);
        tick();
        tick();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0);
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        chk("async_cnt", illegal_count, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mcnt = 0;

        // Backpressure: four ops, consumer stalled, then released
        begin
            int nxt;
            logic acc;
            nxt = 1;
            got.delete();
            for (int it = 0; it < 20; it++) begin
                if (it == 3) begin
                    chk("bp_m_a", out_a, 32'd1);
                    chk("bp_in_ready", in_ready, 1'b0);
                end
                out_ready = (it >= 3);
                if (nxt <= 4) drive(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, W'(nxt), '0);
                else          drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0);
                acc = in_valid && in_ready;
                if (out_valid && out_ready) got.push_back(out_a);
                tick();
                if (acc) nxt++;
            end
            chk("bp_count", got.size(), 4);
            for (int k = 0; k < got.size() && k < 4; k++) chk("bp_order", got[k], W'(k + 1));
        end

        // Stability under stall while inputs keep changing
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 3'b100, 1'b0, 1'b0, 32'd7, 32'd8);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b1, 1'b1, $urandom, $urandom);
            chk("stall_a", out_a, 32'd7);
            chk("stall_b", out_b, 32'd8);
            chk("stall_ctrl", out_alu_control, 3'b011);
            tick();
        end

        // Flush with M and S full, input in the same cycle dropped
        flush = 1'b1;
        drive(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 32'd99, 32'd99);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_reappear", out_valid, 1'b0);
            tick();
        end

        // Saturation on the 2-bit counter instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd3, 3'd0, 1'b0, 1'b0, W'(i), '0);
            tick();
            chk("sat_cnt", illegal_count2, exp_cnt[i]);
        end
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
